// File: rtl/axi_batch_cmd_scheduler_if.sv
// Host-side command push bus for axi_batch_cmd_scheduler.
// master = host control path, slave = scheduler.
interface axi_batch_cmd_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_wr_bram_start;
    logic [4:0]  cmd_wr_bram_end;
    logic [15:0] cmd_wr_addr_start;
    logic [15:0] cmd_wr_addr_count;
    logic [2:0]  cmd_rd_bram_start;
    logic [2:0]  cmd_rd_bram_end;
    logic [15:0] cmd_rd_addr_start;
    logic [15:0] cmd_rd_addr_count;

    modport master (
        output cmd_valid, cmd_op,
        output cmd_wr_bram_start, cmd_wr_bram_end, cmd_wr_addr_start, cmd_wr_addr_count,
        output cmd_rd_bram_start, cmd_rd_bram_end, cmd_rd_addr_start, cmd_rd_addr_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op,
        input  cmd_wr_bram_start, cmd_wr_bram_end, cmd_wr_addr_start, cmd_wr_addr_count,
        input  cmd_rd_bram_start, cmd_rd_bram_end, cmd_rd_addr_start, cmd_rd_addr_count,
        output cmd_ready
    );
endinterface

// File: rtl/axi_batch_cmd_scheduler.sv
// Buffers host transfer commands, validates them and drives the AXI batch FSM,
// holding each request until its done pulse and forcing a zero-code gap after it.
//
// state   | meaning
// IDLE    | waiting for a FIFO head; illegal heads are popped and reported
// WAIT    | request presented to the batch FSM, watchdog running
// RELEASE | one cycle of Instruction_code = 0 before the next request
module axi_batch_cmd_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi_batch_cmd_scheduler_if.slave host,
    input  logic                     flush,
    output logic [7:0]               Instruction_code,
    output logic [4:0]               wr_bram_start,
    output logic [4:0]               wr_bram_end,
    output logic [15:0]              wr_addr_start,
    output logic [15:0]              wr_addr_count,
    output logic [2:0]               rd_bram_start,
    output logic [2:0]               rd_bram_end,
    output logic [15:0]              rd_addr_start,
    output logic [15:0]              rd_addr_count,
    input  logic                     batch_write_done,
    input  logic                     batch_read_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     cmd_done,
    output logic [1:0]               cmd_done_op,
    output logic                     err_illegal,
    output logic                     err_timeout
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
    localparam logic [15:0]     WD_LOAD = 16'(TIMEOUT);

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  wr_bram_start;
        logic [4:0]  wr_bram_end;
        logic [15:0] wr_addr_start;
        logic [15:0] wr_addr_count;
        logic [2:0]  rd_bram_start;
        logic [2:0]  rd_bram_end;
        logic [15:0] rd_addr_start;
        logic [15:0] rd_addr_count;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    cmd_t          in_cmd;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    state_t        state_next;
    logic          push;
    logic          pop;
    logic          issue;
    logic          illegal;
    logic          complete;
    logic          abort;
    logic          head_legal;
    logic          done_now;
    logic          wr_ok;
    logic          rd_ok;
    logic          wr_seen;
    logic          rd_seen;
    logic [1:0]    cur_op;
    logic [15:0]   wd_cnt;

    assign in_cmd = '{host.cmd_op,
                      host.cmd_wr_bram_start, host.cmd_wr_bram_end,
                      host.cmd_wr_addr_start, host.cmd_wr_addr_count,
                      host.cmd_rd_bram_start, host.cmd_rd_bram_end,
                      host.cmd_rd_addr_start, host.cmd_rd_addr_count};
    assign head   = mem[rd_ptr];

    assign host.cmd_ready = (fifo_count < FULL);
    assign push           = host.cmd_valid && host.cmd_ready && !flush;

    assign wr_ok = (head.wr_bram_start <= head.wr_bram_end) && (head.wr_addr_count != 16'd0);
    assign rd_ok = (head.rd_bram_start <= head.rd_bram_end) && (head.rd_addr_count != 16'd0);

    always_comb begin
        head_legal = 1'b0;
        case (head.op)
            2'd1:    head_legal = wr_ok;
            2'd2:    head_legal = rd_ok;
            2'd3:    head_legal = wr_ok && rd_ok;
            default: head_legal = 1'b0;
        endcase
    end

    // Duplex completes once both sides are seen, in any order or together.
    always_comb begin
        done_now = 1'b0;
        case (cur_op)
            2'd1:    done_now = batch_write_done;
            2'd2:    done_now = batch_read_done;
            2'd3:    done_now = (batch_write_done || wr_seen) && (batch_read_done || rd_seen);
            default: done_now = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        illegal    = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if ((fifo_count != '0) && !flush) begin
                    if (head_legal) begin
                        issue      = 1'b1;
                        state_next = WAIT;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (done_now) begin
                    complete   = 1'b1;
                    state_next = RELEASE;
                end else if (wd_cnt == 16'd1) begin
                    abort      = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign pop = issue || illegal;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= in_cmd;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    // Watchdog is a down-counter: loaded with TIMEOUT on issue, aborts at 1.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            Instruction_code <= '0;
            cur_op           <= '0;
            wr_bram_start    <= '0;
            wr_bram_end      <= '0;
            wr_addr_start    <= '0;
            wr_addr_count    <= '0;
            rd_bram_start    <= '0;
            rd_bram_end      <= '0;
            rd_addr_start    <= '0;
            rd_addr_count    <= '0;
            wd_cnt           <= '0;
            wr_seen          <= 1'b0;
            rd_seen          <= 1'b0;
            busy             <= 1'b0;
            cmd_done         <= 1'b0;
            cmd_done_op      <= '0;
            err_illegal      <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            busy        <= (state_next != IDLE);
            cmd_done    <= complete;
            err_illegal <= illegal;
            err_timeout <= abort;
            if (complete) cmd_done_op <= cur_op;
            if (issue) begin
                Instruction_code <= {6'b0, head.op};
                cur_op           <= head.op;
                wr_bram_start    <= head.wr_bram_start;
                wr_bram_end      <= head.wr_bram_end;
                wr_addr_start    <= head.wr_addr_start;
                wr_addr_count    <= head.wr_addr_count;
                rd_bram_start    <= head.rd_bram_start;
                rd_bram_end      <= head.rd_bram_end;
                rd_addr_start    <= head.rd_addr_start;
                rd_addr_count    <= head.rd_addr_count;
                wd_cnt           <= WD_LOAD;
                wr_seen          <= 1'b0;
                rd_seen          <= 1'b0;
            end else if (state == WAIT) begin
                if (complete || abort) Instruction_code <= '0;
                else                   wd_cnt <= wd_cnt - 1'b1;
                if (batch_write_done) wr_seen <= 1'b1;
                if (batch_read_done)  rd_seen <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_batch_cmd_scheduler.sv
// Directed bench for axi_batch_cmd_scheduler: main instance with the default
// watchdog, second instance with TIMEOUT=8 for the abort path.
module tb_axi_batch_cmd_scheduler;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic flush = 1'b0;
    logic bwd = 1'b0;
    logic brd = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [7:0]  code;
    logic [4:0]  wr_bram_start, wr_bram_end;
    logic [15:0] wr_addr_start, wr_addr_count;
    logic [2:0]  rd_bram_start, rd_bram_end;
    logic [15:0] rd_addr_start, rd_addr_count;
    logic        busy, cmd_done, err_illegal, err_timeout;
    logic [2:0]  fifo_count;
    logic [1:0]  cmd_done_op;

    logic        t_flush = 1'b0;
    logic        t_bwd = 1'b0;
    logic        t_brd = 1'b0;
    logic [7:0]  t_code;
    logic [4:0]  t_wbs, t_wbe;
    logic [15:0] t_was, t_wac;
    logic [2:0]  t_rbs, t_rbe;
    logic [15:0] t_ras, t_rac;
    logic        t_busy, t_cmd_done, t_err_illegal, t_err_timeout;
    logic [2:0]  t_fifo_count;
    logic [1:0]  t_cmd_done_op;

    axi_batch_cmd_scheduler_if ifc ();
    axi_batch_cmd_scheduler_if ifc_t ();

    axi_batch_cmd_scheduler #(.DEPTH(4), .TIMEOUT(65535)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .host(ifc), .flush(flush),
        .Instruction_code(code),
        .wr_bram_start(wr_bram_start), .wr_bram_end(wr_bram_end),
        .wr_addr_start(wr_addr_start), .wr_addr_count(wr_addr_count),
        .rd_bram_start(rd_bram_start), .rd_bram_end(rd_bram_end),
        .rd_addr_start(rd_addr_start), .rd_addr_count(rd_addr_count),
        .batch_write_done(bwd), .batch_read_done(brd),
        .busy(busy), .fifo_count(fifo_count), .cmd_done(cmd_done), .cmd_done_op(cmd_done_op),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    axi_batch_cmd_scheduler #(.DEPTH(4), .TIMEOUT(8)) u_dut_t (
        .aclk(aclk), .aresetn(aresetn), .host(ifc_t), .flush(t_flush),
        .Instruction_code(t_code),
        .wr_bram_start(t_wbs), .wr_bram_end(t_wbe),
        .wr_addr_start(t_was), .wr_addr_count(t_wac),
        .rd_bram_start(t_rbs), .rd_bram_end(t_rbe),
        .rd_addr_start(t_ras), .rd_addr_count(t_rac),
        .batch_write_done(t_bwd), .batch_read_done(t_brd),
        .busy(t_busy), .fifo_count(t_fifo_count), .cmd_done(t_cmd_done), .cmd_done_op(t_cmd_done_op),
        .err_illegal(t_err_illegal), .err_timeout(t_err_timeout)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [4:0] wbs, input logic [4:0] wbe,
                           input logic [15:0] was, input logic [15:0] wac,
                           input logic [2:0] rbs, input logic [2:0] rbe,
                           input logic [15:0] ras, input logic [15:0] rac);
        ifc.cmd_op            = op;
        ifc.cmd_wr_bram_start = wbs;
        ifc.cmd_wr_bram_end   = wbe;
        ifc.cmd_wr_addr_start = was;
        ifc.cmd_wr_addr_count = wac;
        ifc.cmd_rd_bram_start = rbs;
        ifc.cmd_rd_bram_end   = rbe;
        ifc.cmd_rd_addr_start = ras;
        ifc.cmd_rd_addr_count = rac;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [4:0] wbs, input logic [4:0] wbe,
                            input logic [15:0] was, input logic [15:0] wac,
                            input logic [2:0] rbs, input logic [2:0] rbe,
                            input logic [15:0] ras, input logic [15:0] rac);
        set_cmd(op, wbs, wbe, was, wac, rbs, rbe, ras, rac);
        ifc.cmd_valid = 1'b1;
        tick();
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({code, fifo_count, busy, ifc.cmd_ready, cmd_done, cmd_done_op, wr_addr_count, rd_addr_count}
            !== {8'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 16'd0}) begin
            fails++;
            $display("FAIL reset_state: code=%0d count=%0d busy=%0d ready=%0d done=%0d, required 0 0 0 1 0",
                     code, fifo_count, busy, ifc.cmd_ready, cmd_done);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_write();
        bit hold_ok = 1'b1;
        push_cmd(2'd1, 5'd0, 5'd3, 16'd0, 16'd16, 3'd0, 3'd0, 16'd0, 16'd0);
        tests++;
        if ({fifo_count, code} !== {3'd1, 8'd0}) begin
            fails++;
            $display("FAIL write_queued: count=%0d code=%0d, required 1 0", fifo_count, code);
        end
        tick();
        tests++;
        if ({code, busy, wr_bram_start, wr_bram_end, wr_addr_start, wr_addr_count}
            !== {8'd1, 1'b1, 5'd0, 5'd3, 16'd0, 16'd16}) begin
            fails++;
            $display("FAIL write_issue: code=%0d busy=%0d wbe=%0d wac=%0d, required 1 1 3 16",
                     code, busy, wr_bram_end, wr_addr_count);
        end
        for (int k = 1; k <= 19; k++) begin
            brd = (k == 5);
            tick();
            brd = 1'b0;
            if (code !== 8'd1 || wr_addr_count !== 16'd16 || cmd_done !== 1'b0) hold_ok = 1'b0;
        end
        tests++;
        if (hold_ok !== 1'b1) begin
            fails++;
            $display("FAIL write_hold: code not held at 1 through WAIT, last code=%0d", code);
        end
        bwd = 1'b1;
        tick();
        bwd = 1'b0;
        tests++;
        if ({code, cmd_done, cmd_done_op, busy, wr_addr_count} !== {8'd0, 1'b1, 2'd1, 1'b1, 16'd16}) begin
            fails++;
            $display("FAIL write_done: code=%0d done=%0d op=%0d busy=%0d wac=%0d, required 0 1 1 1 16",
                     code, cmd_done, cmd_done_op, busy, wr_addr_count);
        end
        tick();
        tests++;
        if ({code, cmd_done, busy} !== {8'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL write_release: code=%0d done=%0d busy=%0d, required 0 0 0", code, cmd_done, busy);
        end
    endtask

    task automatic test_duplex();
        int done_cnt = 0;
        int done_k = 0;
        logic [1:0] op_at = 2'd0;
        push_cmd(2'd3, 5'd1, 5'd2, 16'h0040, 16'd4, 3'd0, 3'd1, 16'h0080, 16'd8);
        tick();
        tests++;
        if ({code, rd_addr_start, rd_addr_count} !== {8'd3, 16'h0080, 16'd8}) begin
            fails++;
            $display("FAIL duplex_issue: code=%0d ras=%0h rac=%0d, required 3 80 8", code, rd_addr_start, rd_addr_count);
        end
        for (int k = 1; k <= 20; k++) begin
            brd = (k == 10);
            bwd = (k == 15);
            tick();
            brd = 1'b0;
            bwd = 1'b0;
            if (cmd_done === 1'b1) begin
                done_cnt++;
                done_k = k;
                op_at  = cmd_done_op;
            end
        end
        tests++;
        if (done_cnt !== 1 || done_k !== 15 || op_at !== 2'd3) begin
            fails++;
            $display("FAIL duplex_done: pulses=%0d at=%0d op=%0d, required 1 15 3", done_cnt, done_k, op_at);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        set_cmd(2'd1, 5'd0, 5'd3, 16'd100, 16'd16, 3'd0, 3'd0, 16'd0, 16'd0);
        ifc.cmd_valid = 1'b1;
        tick();
        set_cmd(2'd1, 5'd0, 5'd3, 16'd101, 16'd16, 3'd0, 3'd0, 16'd0, 16'd0);
        tick();
        tests++;
        if ({fifo_count, code} !== {3'd1, 8'd1}) begin
            fails++;
            $display("FAIL b2b_push_pop: count=%0d code=%0d, required 1 1", fifo_count, code);
        end
        for (int i = 2; i <= 4; i++) begin
            set_cmd(2'd1, 5'd0, 5'd3, 16'(100 + i), 16'd16, 3'd0, 3'd0, 16'd0, 16'd0);
            tick();
        end
        tests++;
        if ({fifo_count, ifc.cmd_ready} !== {3'd4, 1'b0}) begin
            fails++;
            $display("FAIL b2b_full: count=%0d ready=%0d, required 4 0", fifo_count, ifc.cmd_ready);
        end
        set_cmd(2'd1, 5'd0, 5'd3, 16'd105, 16'd16, 3'd0, 3'd0, 16'd0, 16'd0);
        tick();
        ifc.cmd_valid = 1'b0;
        tests++;
        if (fifo_count !== 3'd4) begin
            fails++;
            $display("FAIL b2b_full_hold: count=%0d, required 4", fifo_count);
        end
        for (int n = 0; n < 5; n++) begin
            gap = 0;
            while (code === 8'd0 && gap < 10) begin
                tick();
                gap++;
            end
            tests++;
            if (gap !== ((n == 0) ? 0 : 2) || wr_addr_start !== 16'(100 + n)) begin
                fails++;
                $display("FAIL b2b_order: cmd %0d gap=%0d addr=%0d, required gap %0d addr %0d",
                         n, gap, wr_addr_start, (n == 0) ? 0 : 2, 100 + n);
            end
            tick();
            tick();
            bwd = 1'b1;
            tick();
            bwd = 1'b0;
            tests++;
            if ({cmd_done, cmd_done_op, code} !== {1'b1, 2'd1, 8'd0}) begin
                fails++;
                $display("FAIL b2b_done: cmd %0d done=%0d op=%0d code=%0d, required 1 1 0",
                         n, cmd_done, cmd_done_op, code);
            end
        end
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if ({code, fifo_count} !== {8'd0, 3'd0}) begin
            fails++;
            $display("FAIL b2b_no_extra: code=%0d count=%0d, required 0 0", code, fifo_count);
        end
    endtask

    task automatic test_illegal();
        int errs = 0;
        int first_t = -1;
        for (int t = 0; t < 10; t++) begin
            ifc.cmd_valid = (t < 4);
            case (t)
                0: set_cmd(2'd0, 5'd0, 5'd3, 16'd0, 16'd16, 3'd0, 3'd1, 16'd0, 16'd8);
                1: set_cmd(2'd1, 5'd5, 5'd2, 16'd0, 16'd4, 3'd0, 3'd0, 16'd0, 16'd0);
                2: set_cmd(2'd2, 5'd0, 5'd0, 16'd0, 16'd0, 3'd0, 3'd1, 16'd0, 16'd0);
                3: set_cmd(2'd2, 5'd0, 5'd0, 16'd0, 16'd0, 3'd1, 3'd4, 16'h0200, 16'd5);
                default: ;
            endcase
            tick();
            if (err_illegal === 1'b1) errs++;
            if (code !== 8'd0 && first_t < 0) first_t = t;
        end
        ifc.cmd_valid = 1'b0;
        tests++;
        if (errs !== 3 || first_t !== 4) begin
            fails++;
            $display("FAIL illegal_errs: pulses=%0d first_issue=%0d, required 3 4", errs, first_t);
        end
        tests++;
        if ({code, rd_bram_start, rd_bram_end, rd_addr_start, rd_addr_count}
            !== {8'd2, 3'd1, 3'd4, 16'h0200, 16'd5}) begin
            fails++;
            $display("FAIL illegal_next_legal: code=%0d rbe=%0d ras=%0h rac=%0d, required 2 4 200 5",
                     code, rd_bram_end, rd_addr_start, rd_addr_count);
        end
        brd = 1'b1;
        tick();
        brd = 1'b0;
        tests++;
        if ({cmd_done, cmd_done_op} !== {1'b1, 2'd2}) begin
            fails++;
            $display("FAIL illegal_done: done=%0d op=%0d, required 1 2", cmd_done, cmd_done_op);
        end
        tick();
        tick();
    endtask

    task automatic test_flush();
        bit any_issue = 1'b0;
        push_cmd(2'd1, 5'd0, 5'd1, 16'h0300, 16'd2, 3'd0, 3'd0, 16'd0, 16'd0);
        tick();
        push_cmd(2'd2, 5'd0, 5'd0, 16'd0, 16'd0, 3'd0, 3'd2, 16'd0, 16'd3);
        push_cmd(2'd1, 5'd2, 5'd2, 16'd0, 16'd1, 3'd0, 3'd0, 16'd0, 16'd0);
        tests++;
        if ({fifo_count, code} !== {3'd2, 8'd1}) begin
            fails++;
            $display("FAIL flush_queued: count=%0d code=%0d, required 2 1", fifo_count, code);
        end
        flush = 1'b1;
        set_cmd(2'd1, 5'd0, 5'd0, 16'd0, 16'd1, 3'd0, 3'd0, 16'd0, 16'd0);
        ifc.cmd_valid = 1'b1;
        tick();
        flush = 1'b0;
        ifc.cmd_valid = 1'b0;
        tests++;
        if ({fifo_count, code, wr_addr_start} !== {3'd0, 8'd1, 16'h0300}) begin
            fails++;
            $display("FAIL flush_empty: count=%0d code=%0d was=%0h, required 0 1 300", fifo_count, code, wr_addr_start);
        end
        tick();
        tick();
        bwd = 1'b1;
        tick();
        bwd = 1'b0;
        tests++;
        if ({cmd_done, cmd_done_op} !== {1'b1, 2'd1}) begin
            fails++;
            $display("FAIL flush_inflight_done: done=%0d op=%0d, required 1 1", cmd_done, cmd_done_op);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (code !== 8'd0) any_issue = 1'b1;
        end
        tests++;
        if ({any_issue, fifo_count} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL flush_no_issue: issued=%0d count=%0d, required 0 0", any_issue, fifo_count);
        end
    endtask

    task automatic test_timeout();
        int to_k = 0;
        int to_cnt = 0;
        int done_cnt = 0;
        bit code_ok = 1'b1;
        logic [7:0] code8 = 8'hff;
        logic busy8 = 1'b0;
        logic busy9 = 1'b1;
        ifc_t.cmd_op            = 2'd1;
        ifc_t.cmd_wr_bram_start = 5'd0;
        ifc_t.cmd_wr_bram_end   = 5'd7;
        ifc_t.cmd_wr_addr_start = 16'h0010;
        ifc_t.cmd_wr_addr_count = 16'd32;
        ifc_t.cmd_valid = 1'b1;
        tick();
        ifc_t.cmd_valid = 1'b0;
        tick();
        tests++;
        if ({t_code, t_busy} !== {8'd1, 1'b1}) begin
            fails++;
            $display("FAIL timeout_issue: code=%0d busy=%0d, required 1 1", t_code, t_busy);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (t_err_timeout === 1'b1) begin
                to_cnt++;
                if (to_k == 0) to_k = k;
            end
            if (t_cmd_done === 1'b1) done_cnt++;
            if (k < 8 && t_code !== 8'd1) code_ok = 1'b0;
            if (k == 8) begin
                code8 = t_code;
                busy8 = t_busy;
            end
            if (k == 9) busy9 = t_busy;
        end
        tests++;
        if (to_k !== 8 || to_cnt !== 1 || done_cnt !== 0) begin
            fails++;
            $display("FAIL timeout_edge: at=%0d pulses=%0d dones=%0d, required 8 1 0", to_k, to_cnt, done_cnt);
        end
        tests++;
        if ({code_ok, code8, busy8, busy9} !== {1'b1, 8'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL timeout_release: held=%0d code8=%0d busy8=%0d busy9=%0d, required 1 0 1 0",
                     code_ok, code8, busy8, busy9);
        end
    endtask

    task automatic test_reset_mid_wait();
        int done_cnt = 0;
        push_cmd(2'd1, 5'd0, 5'd3, 16'd0, 16'd16, 3'd0, 3'd0, 16'd0, 16'd0);
        push_cmd(2'd2, 5'd0, 5'd0, 16'd0, 16'd0, 3'd0, 3'd1, 16'd0, 16'd4);
        tick();
        tests++;
        if ({code, fifo_count} !== {8'd1, 3'd1}) begin
            fails++;
            $display("FAIL rst_pre: code=%0d count=%0d, required 1 1", code, fifo_count);
        end
        #2;
        aresetn = 1'b0;
        #1;
        tests++;
        if ({code, fifo_count, busy, ifc.cmd_ready, cmd_done, wr_addr_count}
            !== {8'd0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL rst_mid_wait: code=%0d count=%0d busy=%0d ready=%0d done=%0d, required 0 0 0 1 0",
                     code, fifo_count, busy, ifc.cmd_ready, cmd_done);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        bwd = 1'b1;
        tick();
        bwd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cmd_done === 1'b1) done_cnt++;
            tick();
        end
        tests++;
        if (done_cnt !== 0 || code !== 8'd0) begin
            fails++;
            $display("FAIL rst_no_done: dones=%0d code=%0d, required 0 0", done_cnt, code);
        end
    endtask

    initial begin
        ifc.cmd_valid   = 1'b0;
        ifc_t.cmd_valid = 1'b0;
        set_cmd(2'd0, 5'd0, 5'd0, 16'd0, 16'd0, 3'd0, 3'd0, 16'd0, 16'd0);
        ifc_t.cmd_op            = 2'd0;
        ifc_t.cmd_wr_bram_start = 5'd0;
        ifc_t.cmd_wr_bram_end   = 5'd0;
        ifc_t.cmd_wr_addr_start = 16'd0;
        ifc_t.cmd_wr_addr_count = 16'd0;
        ifc_t.cmd_rd_bram_start = 3'd0;
        ifc_t.cmd_rd_bram_end   = 3'd0;
        ifc_t.cmd_rd_addr_start = 16'd0;
        ifc_t.cmd_rd_addr_count = 16'd0;

        test_reset();
        test_write();
        test_duplex();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_timeout();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_batch_cmd_scheduler.md
# axi_batch_cmd_scheduler

Command scheduler in front of the external AXI batch FSM (the transfer controller that sequences BRAM write/read/duplex batches via `Instruction_code`). It buffers transfer commands from the host-side control path in a small FIFO, validates them, and presents each one to the batch FSM: it holds the instruction code and parameters stable until the matching batch-done pulse, then forces a zero-code gap so the FSM cannot re-trigger. It also reports completion, illegal commands and a watchdog timeout.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 65535: maximum cycles in WAIT before abort; 1..65535.

- `aclk` in 1: clock.
- `aresetn` in 1: reset. Asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command push handshake; a push occurs on a rising edge with both high.
- `cmd_op` in 2: 1=WRITE, 2=READ, 3=DUPLEX, 0=illegal.
- `cmd_wr_bram_start`, `cmd_wr_bram_end` in 5 each; `cmd_wr_addr_start`, `cmd_wr_addr_count` in 16 each.
- `cmd_rd_bram_start`, `cmd_rd_bram_end` in 3 each; `cmd_rd_addr_start`, `cmd_rd_addr_count` in 16 each.
- `flush` in 1: synchronous; empties the FIFO; does not affect an in-flight command.
- `Instruction_code` out 8: to batch FSM; 0 = no request.
- `wr_bram_start`, `wr_bram_end` out 5; `wr_addr_start`, `wr_addr_count` out 16; `rd_bram_start`, `rd_bram_end` out 3; `rd_addr_start`, `rd_addr_count` out 16: registered parameters to batch FSM.
- `batch_write_done`, `batch_read_done` in 1: one-cycle pulses from batch FSM.
- `busy` out 1: high in WAIT and RELEASE.
- `fifo_count` out log2(DEPTH)+1: number of entries currently held.
- `cmd_done` out 1, `cmd_done_op` out 2: one-cycle completion pulse, plus the op of the completed command.
- `err_illegal` out 1, `err_timeout` out 1: one-cycle pulses.

## Operation
- FIFO: circular buffer with read/write pointers and a count.
  - `cmd_ready` = (`fifo_count` < DEPTH); combinational from the count.
  - A push and a pop in the same cycle leave the count unchanged.
  - `flush` clears pointers and count; a same-cycle push is dropped.
  - `flush` takes priority over pop.
- Legality check on the FIFO head:
  - op≠0.
  - If op∈{1,3}: wr_bram_start ≤ wr_bram_end and wr_addr_count ≠ 0.
  - If op∈{2,3}: rd_bram_start ≤ rd_bram_end and rd_addr_count ≠ 0.
- State machine:
  - IDLE:
    - If the FIFO is non-empty and the head is illegal: pop it, pulse `err_illegal`, stay in IDLE.
    - If the FIFO is non-empty and the head is legal: pop it, register all parameter outputs, set `Instruction_code`={6'b0,op}, clear the watchdog, go to WAIT.
  - WAIT: outputs are held constant. Completion condition:
    - op1: `batch_write_done`.
    - op2: `batch_read_done`.
    - op3: both pulses in the same cycle, or each seen at some point since issue (tracked with sticky flags).
    - On completion: `Instruction_code`←0, pulse `cmd_done`, set `cmd_done_op`=op, go to RELEASE.
    - Otherwise, if the watchdog reaches TIMEOUT: `Instruction_code`←0, pulse `err_timeout`, go to RELEASE.
    - Done pulses that do not match the in-flight op are ignored.
  - RELEASE: `Instruction_code`=0 for one cycle, then go to IDLE. Parameter outputs keep their last values.
  - Done pulses received in IDLE or RELEASE are ignored.
- Asynchronous reset:
  - FSM→IDLE; FIFO emptied.
  - All registered outputs←0: `Instruction_code`, all parameter outputs, `busy`, `cmd_done`, `cmd_done_op`, `err_*`, `fifo_count`.
  - `cmd_ready` reads 1.
  - A reset mid-WAIT abandons the command without pulsing `cmd_done`.

## Timing
- Push into an empty FIFO at edge E: `Instruction_code` is non-zero after edge E+1, and `busy` is high from E+1.
- Completion pulse sampled at edge D:
  - `Instruction_code`=0 and `cmd_done`=1 after D.
  - The next command's code appears after D+2 at the earliest.
  - `Instruction_code` is therefore 0 for at least 2 cycles. This guarantees the batch FSM is in IDLE with code 0 after its DONE state.
- Parameter outputs change only on the same edge that `Instruction_code` goes non-zero. They are stable throughout WAIT.
- The watchdog counts cycles in WAIT, starting at 1 in the first WAIT cycle. The abort edge is the one where count = TIMEOUT.
- Sustained throughput: one command per (batch latency + 3) cycles.

## Test plan
- Reset: assert `aresetn`=0 mid-WAIT → `Instruction_code`=0, `fifo_count`=0, `busy`=0, `cmd_ready`=1, and no `cmd_done` pulse.
- Single WRITE (op1, bram 0..3, addr 0, count 16); pulse `batch_write_done` 20 cycles after issue → `Instruction_code`=1 held for exactly those cycles, `cmd_done`=1 with `cmd_done_op`=1, then code 0 for 2 cycles.
- DUPLEX with `batch_read_done` at cycle 10 and `batch_write_done` at cycle 15 → `cmd_done` exactly once, on the edge after cycle 15.
- Push 5 commands back-to-back with DEPTH=4 while the first is in WAIT → `cmd_ready`=0 when `fifo_count`=4; all 5 complete in push order.
- Illegal heads (op0; op1 with wr_bram_start=5 > wr_bram_end=2; op2 with rd_addr_count=0) → three `err_illegal` pulses, `Instruction_code` stays 0, and the following legal command still issues.
- TIMEOUT=8 with no done pulse → `err_timeout` on the 8th WAIT cycle, then code 0, RELEASE, IDLE. `flush` asserted while WAIT with 2 queued entries → `fifo_count`=0 and the in-flight command still completes.
